// File: rtl/aes_key_expander.sv
// AES-128 key schedule generator: writes round keys 0..10 into the round key
// memory, one per clock, starting from the accepted cipher key.
module aes_key_expander #(
    parameter int DATA_WIDTH = 128,
    parameter int DEPTH      = 11,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] key_in,
    output logic                  busy,
    output logic                  done,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din
);

    // state  | meaning
    // IDLE   | waiting for start; round key 0 is written on the accepting edge
    // EXPAND | writing round keys 1..10, one per cycle
    // DONE   | single cycle: done pulse registered, busy dropped
    typedef enum logic [1:0] {IDLE, EXPAND, DONE} state_t;

    localparam logic [7:0] SBOX [0:255] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   round_q, round_d;
    logic                    busy_d, done_d, we_d;
    logic [ADDR_WIDTH-1:0]   addr_d;
    logic [DATA_WIDTH-1:0]   din_d;

    logic [7:0]   rcon;
    logic [31:0]  w0, w1, w2, w3, rot, t;
    logic [31:0]  n0, n1, n2, n3;

    always_comb begin
        case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Next round key is derived from the key currently presented on mem_din.
    always_comb begin
        w0  = mem_din[127:96];
        w1  = mem_din[95:64];
        w2  = mem_din[63:32];
        w3  = mem_din[31:0];
        rot = {w3[23:0], w3[31:24]};
        t   = {SBOX[rot[31:24]] ^ rcon, SBOX[rot[23:16]], SBOX[rot[15:8]], SBOX[rot[7:0]]};
        n0  = w0 ^ t;
        n1  = w1 ^ n0;
        n2  = w2 ^ n1;
        n3  = w3 ^ n2;
    end

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        we_d    = 1'b0;
        addr_d  = mem_addr;
        din_d   = mem_din;
        case (state_q)
            IDLE: begin
                if (start) begin
                    din_d   = key_in;
                    addr_d  = '0;
                    we_d    = 1'b1;
                    busy_d  = 1'b1;
                    round_d = ADDR_WIDTH'(1);
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                din_d  = {n0, n1, n2, n3};
                addr_d = round_q;
                we_d   = 1'b1;
                busy_d = 1'b1;
                if (round_q == ADDR_WIDTH'(DEPTH - 1)) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + ADDR_WIDTH'(1);
                end
            end
            DONE: begin
                done_d  = 1'b1;
                round_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
                round_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            round_q  <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            state_q  <= state_d;
            round_q  <= round_d;
            busy     <= busy_d;
            done     <= done_d;
            mem_we   <= we_d;
            mem_addr <= addr_d;
            mem_din  <= din_d;
        end
    end

endmodule

// File: tb/tb_aes_key_expander.sv
// Bench for aes_key_expander: expected writes are queued by the stimulus and
// popped by a monitor that watches the memory write port.
module tb_aes_key_expander;

    logic         clk;
    logic         rst;
    logic         start;
    logic [127:0] key_in;
    logic         busy;
    logic         done;
    logic         mem_we;
    logic [3:0]   mem_addr;
    logic [127:0] mem_din;

    aes_key_expander #(.DATA_WIDTH(128), .DEPTH(11), .ADDR_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .start(start), .key_in(key_in),
        .busy(busy), .done(done), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_din(mem_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [127:0] FIPS_KS [0:10] = '{
        128'h2b7e151628aed2a6abf7158809cf4f3c,
        128'ha0fafe1788542cb123a339392a6c7605,
        128'hf2c295f27a96b9435935807a7359f67f,
        128'h3d80477d4716fe3e1e237e446d7a883b,
        128'hef44a541a8525b7fb671253bdb0bad00,
        128'hd4d1c6f87c839d87caf2b8bc11f915bc,
        128'h6d88a37a110b3efddbf98641ca0093fd,
        128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
        128'head27321b58dbad2312bf5607f8d292f,
        128'hac7766f319fadc2128d12941575c006e,
        128'hd014f9a8c9ee2589e13f0cc8b6630ca6
    };
    localparam logic [127:0] ZERO_KS [0:10] = '{
        128'h00000000000000000000000000000000,
        128'h62636363626363636263636362636363,
        128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa,
        128'h90973450696ccffaf2f457330b0fac99,
        128'hee06da7b876a1581759e42b27e91ee2b,
        128'h7f2e2b88f8443e098dda7cbbf34b9290,
        128'hec614b851425758c99ff09376ab49ba7,
        128'h217517873550620bacaf6b3cc61bf09b,
        128'h0ef903333ba9613897060a04511dfa9f,
        128'hb1d4d8e28a7db9da1d7bb3de4c664941,
        128'hb4ef5bcb3e92e21123e951cf6f8f188e
    };

    typedef struct {
        logic [3:0]   addr;
        logic [127:0] data;
    } wr_t;

    wr_t          exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    logic [127:0] tb_mem [0:15];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Round key memory model: synchronous write, combinational read.
    always @(posedge clk) if (mem_we) tb_mem[mem_addr] <= mem_din;

    int   cyc = 0;
    int   first_cyc = 0;
    int   wr_cnt = 0;
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        wr_t e;
        cyc++;
        if (rst) begin
            wr_cnt    = 0;
            prev_done = 1'b0;
        end else begin
            if (mem_we) begin
                if (mem_addr == 4'd0) first_cyc = cyc;
                wr_cnt++;
                if (exp_q.size() == 0) begin
                    check("unexpected_write_addr", {124'd0, mem_addr}, 128'hffff);
                end else begin
                    e = exp_q.pop_front();
                    check("write_addr", {124'd0, mem_addr}, {124'd0, e.addr});
                    check("write_data", mem_din, e.data);
                    check("busy_during_write", {127'd0, busy}, 128'd1);
                end
            end
            if (done) begin
                check("writes_per_run", 128'(wr_cnt), 128'd11);
                check("done_latency", 128'(cyc - first_cyc), 128'd11);
                check("we_busy_at_done", {126'd0, mem_we, busy}, 128'd0);
                wr_cnt = 0;
                if (prev_done) check("done_one_cycle", 128'd1, 128'd0);
            end
            prev_done = done;
        end
    end

    task automatic push_run(input logic [127:0] ks [0:10]);
        for (int i = 0; i < 11; i++) begin
            wr_t e;
            e.addr = 4'(i);
            e.data = ks[i];
            exp_q.push_back(e);
        end
    endtask

    task automatic wait_done(input string name);
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done) begin
                got = 1;
                break;
            end
        end
        if (!got) check({name, "_done_timeout"}, 128'd0, 128'd1);
    endtask

    task automatic pulse_start(input logic [127:0] k);
        @(posedge clk);
        #1;
        key_in = k;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, "_we"},   {127'd0, mem_we}, 128'd0);
        check({name, "_busy"}, {127'd0, busy},   128'd0);
        check({name, "_done"}, {127'd0, done},   128'd0);
        check({name, "_addr"}, {124'd0, mem_addr}, 128'd0);
        check({name, "_din"},  mem_din, 128'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        start  = 1'b0;
        key_in = '0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // FIPS-197 key, single start pulse
        push_run(FIPS_KS);
        pulse_start(FIPS_KS[0]);
        wait_done("fips");
        repeat (3) @(posedge clk);

        // All-zero key, then read the memory back
        push_run(ZERO_KS);
        pulse_start(128'd0);
        wait_done("zero");
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) check("readback", tb_mem[i], ZERO_KS[i]);

        // start held high for two back-to-back runs
        push_run(FIPS_KS);
        push_run(FIPS_KS);
        @(posedge clk);
        #1;
        key_in = FIPS_KS[0];
        start  = 1'b1;
        wait_done("held1");
        wait_done("held2");
        start  = 1'b0;
        repeat (4) @(posedge clk);

        // key_in change plus stray start during a run
        push_run(FIPS_KS);
        pulse_start(FIPS_KS[0]);
        repeat (3) @(posedge clk);
        #1;
        key_in = 128'hdeadbeef_0123_4567_89ab_cdef_5555aaaa;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        wait_done("midrun");
        repeat (15) @(posedge clk);
        #1;
        check("no_second_run", 128'(exp_q.size()), 128'd0);

        // rst asserted while the 5th write (addr 4) is presented
        push_run(FIPS_KS);
        @(posedge clk);
        #1;
        key_in = FIPS_KS[0];
        start  = 1'b1;
        @(posedge clk);
        #1;
        start  = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_outputs("midrun_reset");
        rst = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        check("idle_after_reset_we", {127'd0, mem_we}, 128'd0);

        // fresh schedule after the abort
        push_run(FIPS_KS);
        pulse_start(FIPS_KS[0]);
        wait_done("after_reset");
        @(posedge clk);
        #1;
        for (int i = 0; i < 11; i++) check("readback_fips", tb_mem[i], FIPS_KS[i]);
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 128'(exp_q.size()), 128'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/aes_key_expander.md
# aes_key_expander

Generates the full AES-128 key schedule from a 128-bit cipher key. It writes all 11 round keys into the round key memory through that memory's write port (`we`/`addr`/`din`). It produces one round key per clock and sits between key load and the encryption datapath, which later reads the stored keys. This block is the writer side of the round key memory interface.

## Interface
Parameters:
- DATA_WIDTH, 128, round key width; fixed at 128 for AES-128.
- DEPTH, 11, number of round keys written (round 0..10).
- ADDR_WIDTH, 4, memory address width.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request expansion of key_in; sampled only in IDLE.
- key_in  input  DATA_WIDTH  cipher key; word w0 = key_in[127:96], w3 = key_in[31:0].
- busy  output  1  high from the first write through the last write.
- done  output  1  one-cycle pulse after the round-10 write.
- mem_we  output  1  write enable to round key memory.
- mem_addr  output  ADDR_WIDTH  write address, 0..10.
- mem_din  output  DATA_WIDTH  round key being written.

## Operation
- FSM states: IDLE, EXPAND, DONE.
- Reset values: FSM in IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_din=0; round counter=0.
- All outputs are registered.
- IDLE with start=1:
  - Register mem_din=key_in, mem_addr=0, mem_we=1, busy=1.
  - Round counter=1; go to EXPAND.
- EXPAND, each cycle, derive the next key from the current mem_din (words w0..w3):
  - t = SubWord(RotWord(w3)) XOR {Rcon[round],24'h0}.
  - RotWord rotates bytes left by 8.
  - SubWord applies the AES S-box to each of the 4 bytes; S-box is internal combinational logic.
  - w0' = w0^t; w1' = w1^w0'; w2' = w2^w1'; w3' = w3^w2'.
  - Register mem_din={w0',w1',w2',w3'}, mem_addr=round, mem_we=1.
  - When round==10: go to DONE. Otherwise round increments.
- Rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- DONE (one cycle): mem_we=0, busy=0, done=1, then return to IDLE.
- mem_din and mem_addr hold their last values while mem_we=0; mem_addr is only meaningful while mem_we=1.
- start while busy or in DONE is ignored and not queued.
- key_in is sampled only at the accepting edge. Later changes do not affect the schedule in progress.
- rst mid-expansion: the next edge returns every output to its reset value and issues no further writes. Memory contents are left partially written; the consumer must rerun.
- rst and start high on the same edge: rst wins.

## Timing
- start sampled high in IDLE at edge E:
  - Edges E..E+10 present writes to addr 0..10, exactly one write per cycle, strictly ascending, with no gaps.
  - Edge E+11 registers done=1 and busy=0.
  - Edge E+12 clears done.
- Total: 11 write cycles + 1 done cycle.
- A new start is accepted no earlier than edge E+12, which is back in IDLE. Back-to-back runs are therefore 12 cycles apart.
- The memory captures each key on the edge following its presentation, because the memory write is synchronous on the same clk.

## Test plan
- FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c, start pulse:
  - addr0 = the key.
  - addr1 = a0fafe1788542cb123a339392a6c7605.
  - addr10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
  - done exactly 11 cycles after the first write.
- All-zero key:
  - addr1 = 62636363626363636263636362636363.
  - addr10 = b4ef5bcb3e92e21123e951cf6f8f188e.
  - Reading the memory back via its dout matches.
- start held high continuously: exactly 11 writes per run, runs separated by a single DONE cycle, no writes while done=1.
- Change key_in and pulse start during the run: no effect on that run's keys and no second run triggered.
- Assert rst at the 5th write cycle: the next cycle has mem_we=0, busy=0, done=0. A fresh start afterwards produces the correct full schedule.
- Check outputs after rst: all zero. Check that mem_we is high for exactly 11 cycles per run.
